// File: rtl/secded_codec.sv
// secded_codec: systematic SECDED Hamming encoder/decoder with a per-beat detect-only mode.
// Latency 2 cycles (stage 1 = syndrome/parity, stage 2 = correction/flags), 1 beat per cycle.
// Backpressure: in_ready = !out_valid || out_ready; the whole pipeline freezes while the output stalls.
// Optional feature macro: ECC_STATS_EN builds the ce/ue counters and the sticky alarm.
module secded_codec #(
   parameter int DATA_WIDTH   = 8,
   parameter int COUNT_WIDTH  = 16,
   parameter int ALARM_THRESH = 4,
   // smallest r with 2^r >= DATA_WIDTH + r + 1 over the legal 4..64 range
   localparam int R = (DATA_WIDTH <= 4)  ? 3 :
                      (DATA_WIDTH <= 11) ? 4 :
                      (DATA_WIDTH <= 26) ? 5 :
                      (DATA_WIDTH <= 57) ? 6 : 7,
   localparam int CW_WIDTH = DATA_WIDTH + R + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_op,
   input  logic                   in_corr_en,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [CW_WIDTH-1:0]    in_codeword,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_op,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [CW_WIDTH-1:0]    out_codeword,
   output logic [R-1:0]           out_syndrome,
   output logic                   out_err_single,
   output logic                   out_err_double,
   input  logic                   stat_clear,
   output logic [COUNT_WIDTH-1:0] ce_count,
   output logic [COUNT_WIDTH-1:0] ue_count,
   output logic                   alarm
);

   // Hamming position of data bit idx: the idx-th non-power-of-two position (3, 5, 6, 7, 9, ...)
   function automatic int data_pos(input int idx);
      int pos;
      int cnt;
      pos = 0;
      cnt = 0;
      for (int p = 3; p < 128; p++) begin
         if (((p & (p - 1)) != 0) && (cnt <= idx)) begin
            pos = p;
            cnt = cnt + 1;
         end
      end
      return pos;
   endfunction

   // Constant lookup of each data bit's position; every position fits in R bits
   logic [R-1:0] pos_lut [DATA_WIDTH];
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_pos
      assign pos_lut[gi] = R'(data_pos(gi));
   end

   logic                  advance;
   logic [DATA_WIDTH-1:0] chk_src;
   logic [R-1:0]          chk_calc;
   logic [CW_WIDTH-1:0]   s1_cw_d;
   logic [R-1:0]          s1_syn_d;
   logic                  s1_par_d;

   logic                  s1_vld_q;
   logic                  s1_op_q;
   logic                  s1_corr_q;
   logic [CW_WIDTH-1:0]   s1_cw_q;
   logic [R-1:0]          s1_syn_q;
   logic                  s1_par_q;

   logic [CW_WIDTH-1:0]   flip_mask;
   logic                  hit;
   logic                  single_d;
   logic                  double_d;
   logic [CW_WIDTH-1:0]   out_cw_d;

   logic                  out_valid_q;
   logic                  out_op_q;
   logic [CW_WIDTH-1:0]   out_cw_q;
   logic [R-1:0]          out_syn_q;
   logic                  out_single_q;
   logic                  out_double_q;

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   // Recompute check bits of the incoming word and form the stage 1 next state
   always_comb begin
      chk_src  = in_op ? in_codeword[DATA_WIDTH-1:0] : in_data;
      chk_calc = '0;
      for (int j = 0; j < R; j++) begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (pos_lut[i][j]) chk_calc[j] = chk_calc[j] ^ chk_src[i];
         end
      end
      if (in_op) begin
         s1_cw_d  = in_codeword;
         s1_syn_d = chk_calc ^ in_codeword[DATA_WIDTH+R-1:DATA_WIDTH];
         s1_par_d = ^in_codeword;
      end else begin
         // encode: {overall parity, check bits, data}; syndrome and parity stay 0
         s1_cw_d  = {^{chk_calc, in_data}, chk_calc, in_data};
         s1_syn_d = '0;
         s1_par_d = 1'b0;
      end
   end

   // Stage 1: register payload, op, correction mode, syndrome and overall parity
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_op_q   <= 1'b0;
         s1_corr_q <= 1'b0;
         s1_cw_q   <= '0;
         s1_syn_q  <= '0;
         s1_par_q  <= 1'b0;
      end else if (advance) begin
         s1_vld_q  <= in_valid;
         s1_op_q   <= in_op;
         s1_corr_q <= in_corr_en;
         s1_cw_q   <= s1_cw_d;
         s1_syn_q  <= s1_syn_d;
         s1_par_q  <= s1_par_d;
      end
   end

   // Classify the syndrome and build a one-hot repair mask for a single faulty bit
   always_comb begin
      flip_mask = '0;
      hit       = 1'b0;
      single_d  = 1'b0;
      double_d  = 1'b0;
      if (s1_op_q) begin
         if (s1_par_q) begin
            if (s1_syn_q == '0) begin
               // only the overall parity bit itself is wrong
               flip_mask[CW_WIDTH-1] = 1'b1;
               hit                   = 1'b1;
            end else begin
               // power-of-two syndrome names a check bit
               for (int j = 0; j < R; j++) begin
                  if (s1_syn_q == (R'(1) << j)) begin
                     flip_mask[DATA_WIDTH+j] = 1'b1;
                     hit                     = 1'b1;
                  end
               end
               for (int i = 0; i < DATA_WIDTH; i++) begin
                  if (s1_syn_q == pos_lut[i]) begin
                     flip_mask[i] = 1'b1;
                     hit          = 1'b1;
                  end
               end
            end
            // odd parity with a syndrome past the last used position cannot be one error
            single_d = hit;
            double_d = !hit;
         end else begin
            double_d = (s1_syn_q != '0);
         end
      end
      out_cw_d = s1_corr_q ? (s1_cw_q ^ flip_mask) : s1_cw_q;
   end

   // Stage 2: register the (corrected) result and error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_op_q     <= 1'b0;
         out_cw_q     <= '0;
         out_syn_q    <= '0;
         out_single_q <= 1'b0;
         out_double_q <= 1'b0;
      end else if (advance) begin
         out_valid_q  <= s1_vld_q;
         out_op_q     <= s1_op_q;
         out_cw_q     <= out_cw_d;
         out_syn_q    <= s1_syn_q;
         out_single_q <= single_d;
         out_double_q <= double_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_op         = out_op_q;
   assign out_codeword   = out_cw_q;
   assign out_data       = out_cw_q[DATA_WIDTH-1:0];
   assign out_syndrome   = out_syn_q;
   assign out_err_single = out_single_q;
   assign out_err_double = out_double_q;

`ifdef ECC_STATS_EN
   logic                   consume;
   logic                   ce_inc;
   logic                   ue_inc;
   logic [COUNT_WIDTH-1:0] ce_count_q;
   logic [COUNT_WIDTH-1:0] ue_count_q;
   logic                   alarm_q;

   assign consume = out_valid_q && out_ready && out_op_q;
   assign ce_inc  = consume && out_single_q && (ce_count_q != '1);
   assign ue_inc  = consume && out_double_q && (ue_count_q != '1);

   // Saturating error counters and sticky alarm; clear wins over any increment
   always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
         ce_count_q <= '0;
         ue_count_q <= '0;
         alarm_q    <= 1'b0;
      end else begin
         if (ce_inc) ce_count_q <= ce_count_q + COUNT_WIDTH'(1);
         if (ue_inc) ue_count_q <= ue_count_q + COUNT_WIDTH'(1);
         if ((ce_count_q >= COUNT_WIDTH'(ALARM_THRESH)) || ue_inc) alarm_q <= 1'b1;
      end
   end

   assign ce_count = ce_count_q;
   assign ue_count = ue_count_q;
   assign alarm    = alarm_q;
`else
   logic stats_unused;
   assign stats_unused = stat_clear ^ (ALARM_THRESH > 0);
   assign ce_count     = '0;
   assign ue_count     = '0;
   assign alarm        = 1'b0;
`endif

endmodule
